// File: rtl/noc_pkg.sv
// Shared router definitions: flit layout, flit-type codes and port FSM states.
package noc_pkg;

    localparam int FLIT_W_DEFAULT = 34;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef logic [FLIT_W_DEFAULT-1:0] flit_t;

    // state     | meaning
    // ST_IDLE   | port free, follows the arbiter grant
    // ST_LOCKED | port held by owner until its tail flit is sent
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } port_state_t;

endpackage

// File: rtl/onehot_enc.sv
// One-hot to index encoder with one-hot / multi-hot detection.
module onehot_enc #(
    parameter int  N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          is_onehot,
    output logic          multi
);

    logic seen;

    // OR together the indices of set bits; only meaningful when exactly one is set
    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
                idx  = idx | IW'(i);
            end
        end
        is_onehot = seen & ~multi;
    end

endmodule

// File: rtl/noc_output_port.sv
// Router output port: grant decode, packet lock, credit flow control, registered link.
module noc_output_port
    import noc_pkg::*;
#(
    parameter int  FLIT_W  = FLIT_W_DEFAULT,
    parameter int  NUM_IN  = 8,
    parameter int  CREDITS = 4,
    localparam int SW      = $clog2(NUM_IN),
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        arbitration,
    input  logic [NUM_IN*FLIT_W-1:0] in_flit,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_valid,
    input  logic                     credit_in,
    output logic                     locked,
    output logic [SW-1:0]            owner,
    output logic                     err
);

    port_state_t       state, state_nxt;
    logic [CW-1:0]     credits;
    logic [SW-1:0]     arb_idx, src, owner_nxt;
    logic              arb_onehot, arb_multi;
    logic [FLIT_W-1:0] cand;
    logic [1:0]        ftype;
    logic              has_credit, pop, send, err_set;

    onehot_enc #(.N(NUM_IN)) u_enc (
        .vec       (arbitration),
        .idx       (arb_idx),
        .is_onehot (arb_onehot),
        .multi     (arb_multi)
    );

    // Next-state, pop/send decisions and error detection
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        pop        = 1'b0;
        send       = 1'b0;
        err_set    = 1'b0;
        src        = (state == ST_IDLE) ? arb_idx : owner;
        cand       = in_flit[src*FLIT_W +: FLIT_W];
        ftype      = cand[FLIT_W-1 -: 2];
        has_credit = (credits != '0);

        case (state)
            ST_IDLE: begin
                if (arb_multi) begin
                    err_set = 1'b1;
                end else if (arb_onehot && in_valid[src] && has_credit) begin
                    pop = 1'b1;
                    case (ftype)
                        FT_HEAD: begin
                            send      = 1'b1;
                            state_nxt = ST_LOCKED;
                            owner_nxt = src;
                        end
                        FT_SINGLE: send = 1'b1;
                        default:   err_set = 1'b1;   // stray body/tail is dropped
                    endcase
                end
            end
            ST_LOCKED: begin
                if (in_valid[src] && has_credit) begin
                    pop  = 1'b1;
                    send = 1'b1;
                    case (ftype)
                        FT_TAIL: begin
                            state_nxt = ST_IDLE;
                            owner_nxt = '0;
                        end
                        FT_BODY: ;
                        default: err_set = 1'b1;     // forwarded anyway, lock kept
                    endcase
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (credit_in && !send && (credits == CW'(CREDITS))) err_set = 1'b1;

        in_ready = '0;
        if (pop && !rst) in_ready[src] = 1'b1;
    end

    // State, owner, credit counter, link registers and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            credits   <= CW'(CREDITS);
            out_valid <= 1'b0;
            out_flit  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            out_valid <= send;
            if (send) out_flit <= cand;
            if (err_set) err <= 1'b1;
            case ({send, credit_in})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   if (credits != CW'(CREDITS)) credits <= credits + CW'(1);
                default: ;
            endcase
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_noc_output_port.sv
// Directed bench for noc_output_port: vector table plus hand-written corner sequences.
module tb_noc_output_port;
    import noc_pkg::*;

    localparam int FW = 34;
    localparam int NI = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NI-1:0]   arbitration;
    logic [NI*FW-1:0] in_flit;
    logic [NI-1:0]   in_valid;
    logic [NI-1:0]   in_ready;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic            credit_in;
    logic            locked;
    logic [2:0]      owner;
    logic            err;

    int total = 0;
    int bad   = 0;

    noc_output_port #(.FLIT_W(FW), .NUM_IN(NI), .CREDITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .arbitration (arbitration),
        .in_flit     (in_flit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_flit    (out_flit),
        .out_valid   (out_valid),
        .credit_in   (credit_in),
        .locked      (locked),
        .owner       (owner),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] arb;
        logic [7:0] valid;
        logic [1:0] ft;
        logic       cred;
        logic [7:0] exp_ready;
        logic       exp_ov;
        int         exp_src;
        logic       exp_locked;
        logic [2:0] exp_owner;
        logic       exp_err;
        logic [2:0] exp_cred;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [7:0] a, logic [7:0] v, logic [1:0] t, logic c,
                                logic [7:0] er, logic ov, int s, logic lk, logic [2:0] own,
                                logic e, logic [2:0] cr);
        vec_t x;
        x.rst = r; x.arb = a; x.valid = v; x.ft = t; x.cred = c;
        x.exp_ready = er; x.exp_ov = ov; x.exp_src = s; x.exp_locked = lk;
        x.exp_owner = own; x.exp_err = e; x.exp_cred = cr;
        return x;
    endfunction

    function automatic logic [FW-1:0] tag_flit(logic [1:0] t, int tag, int src);
        return {t, 8'hC0, 8'(tag), 8'h00, 8'(src)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [7:0] a, logic [7:0] v, logic [1:0] t, logic c, int tag);
        rst         = r;
        arbitration = a;
        in_valid    = v;
        credit_in   = c;
        for (int i = 0; i < NI; i++) in_flit[i*FW +: FW] = tag_flit(t, tag, i);
    endtask

    initial begin
        rst = 1'b1; arbitration = '0; in_valid = '0; credit_in = 1'b0; in_flit = '0;

        // reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'h0);
        chk("rst_ov", 64'(out_valid), 64'h0);
        chk("rst_flit", 64'(out_flit), 64'h0);
        chk("rst_locked", 64'(locked), 64'h0);
        chk("rst_owner", 64'(owner), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_cred", 64'(dut.credits), 64'd4);

        // single-flit packet from input 3
        @(negedge clk);
        arbitration = 8'b0000_1000;
        in_valid    = 8'b0000_1000;
        in_flit[3*FW +: FW] = {FT_SINGLE, 32'hA5A5_A5A5};
        #1 chk("single_ready", 64'(in_ready), 64'h08);
        @(posedge clk); #1;
        chk("single_ov", 64'(out_valid), 64'h1);
        chk("single_flit", 64'(out_flit), 64'({FT_SINGLE, 32'hA5A5_A5A5}));
        chk("single_cred", 64'(dut.credits), 64'd3);
        chk("single_locked", 64'(locked), 64'h0);
        @(negedge clk);
        arbitration = '0; in_valid = '0; credit_in = 1'b1;
        @(posedge clk); #1;
        chk("single_ov_drop", 64'(out_valid), 64'h0);
        chk("single_cred_back", 64'(dut.credits), 64'd4);

        // table: rst arb valid type cred | ready ov src locked owner err credits
        tbl.push_back(mk(0, 8'h08, 8'h08, FT_SINGLE, 0, 8'h08, 1, 3, 0, 0, 0, 3));
        tbl.push_back(mk(0, 8'h00, 8'h00, FT_BODY,   1, 8'h00, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 8'h20, 8'h22, FT_HEAD,   0, 8'h20, 1, 5, 1, 5, 0, 3));
        tbl.push_back(mk(0, 8'h02, 8'h22, FT_BODY,   0, 8'h20, 1, 5, 1, 5, 0, 2));
        tbl.push_back(mk(0, 8'h02, 8'h22, FT_BODY,   1, 8'h20, 1, 5, 1, 5, 0, 2));
        tbl.push_back(mk(0, 8'h02, 8'h22, FT_TAIL,   0, 8'h20, 1, 5, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h02, 8'h22, FT_SINGLE, 0, 8'h02, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h02, 8'h02, FT_SINGLE, 1, 8'h00, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, FT_BODY,   1, 8'h00, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 8'h00, 8'h00, FT_BODY,   1, 8'h00, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 8'h00, 8'h00, FT_BODY,   1, 8'h00, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 8'h00, 8'h00, FT_BODY,   1, 8'h00, 0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(1, 8'h00, 8'h00, FT_BODY,   0, 8'h00, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 8'h06, 8'h06, FT_SINGLE, 0, 8'h00, 0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(1, 8'h00, 8'h00, FT_BODY,   0, 8'h00, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 8'h10, 8'h10, FT_BODY,   0, 8'h10, 0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(1, 8'h00, 8'h00, FT_BODY,   0, 8'h00, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 8'h04, 8'h04, FT_HEAD,   0, 8'h04, 1, 2, 1, 2, 0, 3));
        tbl.push_back(mk(0, 8'h00, 8'h04, FT_BODY,   0, 8'h04, 1, 2, 1, 2, 0, 2));
        tbl.push_back(mk(1, 8'h00, 8'h00, FT_BODY,   0, 8'h00, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 8'h08, 8'h08, FT_BODY,   0, 8'h08, 0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(1, 8'h00, 8'h00, FT_BODY,   0, 8'h00, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 8'h01, 8'h01, FT_HEAD,   0, 8'h01, 1, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 8'h00, 8'h01, FT_SINGLE, 0, 8'h01, 1, 0, 1, 0, 1, 2));
        tbl.push_back(mk(0, 8'h00, 8'h01, FT_TAIL,   0, 8'h01, 1, 0, 0, 0, 1, 1));

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive(tbl[k].rst, tbl[k].arb, tbl[k].valid, tbl[k].ft, tbl[k].cred, k);
            #1 chk($sformatf("v%0d_ready", k), 64'(in_ready), 64'(tbl[k].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("v%0d_ov", k), 64'(out_valid), 64'(tbl[k].exp_ov));
            if (tbl[k].exp_ov)
                chk($sformatf("v%0d_flit", k), 64'(out_flit),
                    64'(tag_flit(tbl[k].ft, k, tbl[k].exp_src)));
            if (tbl[k].rst)
                chk($sformatf("v%0d_flit_rst", k), 64'(out_flit), 64'h0);
            chk($sformatf("v%0d_locked", k), 64'(locked), 64'(tbl[k].exp_locked));
            chk($sformatf("v%0d_owner", k), 64'(owner), 64'(tbl[k].exp_owner));
            chk($sformatf("v%0d_err", k), 64'(err), 64'(tbl[k].exp_err));
            chk($sformatf("v%0d_cred", k), 64'(dut.credits), 64'(tbl[k].exp_cred));
        end

        // credit exhaustion: long packet from input 6 with no credit return
        @(negedge clk);
        drive(1, 8'h00, 8'h00, FT_BODY, 0, 100);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(0, 8'h40, 8'h40, (c == 0) ? FT_HEAD : FT_BODY, 0, 101 + c);
            #1 chk($sformatf("exh_ready%0d", c), 64'(in_ready), 64'h40);
            @(posedge clk); #1;
            chk($sformatf("exh_ov%0d", c), 64'(out_valid), 64'h1);
        end
        chk("exh_cred0", 64'(dut.credits), 64'd0);
        @(negedge clk);
        drive(0, 8'h40, 8'h40, FT_BODY, 0, 110);
        #1 chk("exh_stall_ready", 64'(in_ready), 64'h00);
        @(posedge clk); #1;
        chk("exh_stall_ov", 64'(out_valid), 64'h0);
        chk("exh_stall_locked", 64'(locked), 64'h1);
        chk("exh_stall_owner", 64'(owner), 64'd6);
        @(negedge clk);
        drive(0, 8'h40, 8'h40, FT_BODY, 1, 111);
        #1 chk("exh_credit_cycle_ready", 64'(in_ready), 64'h00);
        @(posedge clk); #1;
        chk("exh_credit_cycle_ov", 64'(out_valid), 64'h0);
        @(negedge clk);
        drive(0, 8'h40, 8'h40, FT_BODY, 0, 112);
        #1 chk("exh_resume_ready", 64'(in_ready), 64'h40);
        @(posedge clk); #1;
        chk("exh_resume_ov", 64'(out_valid), 64'h1);
        chk("exh_resume_flit", 64'(out_flit), 64'(tag_flit(FT_BODY, 112, 6)));
        chk("exh_resume_err", 64'(err), 64'h0);
        @(negedge clk);
        drive(0, 8'h00, 8'h00, FT_BODY, 0, 113);
        #1 chk("exh_nocred_ready", 64'(in_ready), 64'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
